// File: rtl/add16_arbiter_if.sv
// Request/response bundle between N_REQ adder clients and add16_arbiter.
// req_lock exists only when ADD16_ARBITER_LOCK_EN is defined.
interface add16_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [15:0]         rsp_data;
  logic                busy;
`ifdef ADD16_ARBITER_LOCK_EN
  logic [N_REQ-1:0]    req_lock;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, req_lock,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, req_lock,
    output req_ready, rsp_valid, rsp_data, busy
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
`endif
endinterface

// File: rtl/add16_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-lookahead adder (add16) among N_REQ clients.
// Define ADD16_ARBITER_LOCK_EN to add req_lock, which pins the grant to one client across transactions.

module add16_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum
);
  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [3:0] c_s;

  // in-group carries fully expanded from bit generate/propagate
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    sum    = p_s ^ c_s;
  end
endmodule

module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [2:0] grp_g_s;
  logic [2:0] grp_p_s;
  logic [3:0] grp_c_s;

  // group generate in bit 1, group propagate in bit 0
  function automatic logic [1:0] group_gp(input logic [3:0] a4, input logic [3:0] b4);
    logic [3:0] g;
    logic [3:0] p;
    g = a4 & b4;
    p = a4 ^ b4;
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // second-level lookahead produces each group's carry-in directly
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      {grp_g_s[k], grp_p_s[k]} = group_gp(a[4*k +: 4], b[4*k +: 4]);
    end
    grp_c_s[0] = cin;
    grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & cin);
    grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0]) | (grp_p_s[1] & grp_p_s[0] & cin);
    grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1])
               | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
               | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & cin);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      add16_cla4 u_cla4 (
        .a   (a[4*gi +: 4]),
        .b   (b[4*gi +: 4]),
        .cin (grp_c_s[gi]),
        .sum (sum[4*gi +: 4])
      );
    end
  endgenerate
endmodule

module add16_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input logic            clk,
  input logic            rst_n,
  add16_arbiter_if.slave bus
);
  localparam int DW = 16;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [DW-1:0]    op_a_r;
  logic [DW-1:0]    op_b_r;
  logic [DW-1:0]    rsp_data_r;
  logic [N_REQ-1:0] rsp_valid_r;
  logic             busy_r;
  logic [PTR_W-1:0] last_grant_r;
  logic [PTR_W:0]   pick_s;
  logic             found_s;
  logic [PTR_W-1:0] win_s;
  logic             accept_s;
  logic [N_REQ-1:0] req_ready_s;
  logic [DW-1:0]    sum_s;
`ifdef ADD16_ARBITER_LOCK_EN
  logic             lock_r;
`endif

  // first set bit strictly after last, wrapping; result is {found, index}
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [PTR_W-1:0] last);
    logic [PTR_W:0] res;
    int             idx;
    res = {(PTR_W+1){1'b0}};
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (valid[idx]) begin
        res = {1'b1, PTR_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  add16 u_add16 (
    .a   (op_a_r),
    .b   (op_b_r),
    .cin (1'b0),
    .sum (sum_s)
  );

  // winner selection and next-state decode; req_ready is only raised in IDLE
  always_comb begin
    state_s     = state_r;
    req_ready_s = {N_REQ{1'b0}};
    accept_s    = 1'b0;
    pick_s      = rr_pick(bus.req_valid, last_grant_r);
    found_s     = pick_s[PTR_W];
    win_s       = pick_s[PTR_W-1:0];
`ifdef ADD16_ARBITER_LOCK_EN
    // a locked owner is always last_grant_r, so only its request is considered
    if (lock_r) begin
      found_s = bus.req_valid[last_grant_r];
      win_s   = last_grant_r;
    end else begin
      found_s = pick_s[PTR_W];
      win_s   = pick_s[PTR_W-1:0];
    end
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s     = EXEC;
          accept_s    = 1'b1;
          req_ready_s = ONE_HOT0 << win_s;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (bus.rsp_ready[last_grant_r]) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state, latched operands, grant pointer and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_a_r       <= 16'h0000;
      op_b_r       <= 16'h0000;
      rsp_data_r   <= 16'h0000;
      rsp_valid_r  <= {N_REQ{1'b0}};
      busy_r       <= 1'b0;
      last_grant_r <= PTR_W'(N_REQ - 1);
`ifdef ADD16_ARBITER_LOCK_EN
      lock_r       <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      if (accept_s) begin
        op_a_r       <= bus.req_a[{win_s, 4'b0000} +: DW];
        op_b_r       <= bus.req_b[{win_s, 4'b0000} +: DW];
        last_grant_r <= win_s;
      end
      if (state_r == EXEC) begin
        rsp_data_r  <= sum_s;
        rsp_valid_r <= ONE_HOT0 << last_grant_r;
      end else if ((state_r == RESP) && bus.rsp_ready[last_grant_r]) begin
        rsp_valid_r <= {N_REQ{1'b0}};
      end
`ifdef ADD16_ARBITER_LOCK_EN
      if (accept_s) begin
        lock_r <= bus.req_lock[win_s];
      end
`endif
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = busy_r;
endmodule
